// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART TX byte stream between NUM_REQ requesters.
// Optional UART_ARB_TAG_EN: prefix each new grantee's message with a "<id>:" header.
module uart_tx_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          MAX_HOLD     = 256,
  parameter int          IDLE_TIMEOUT = 64,
  parameter logic [7:0]  EOM_CHAR     = 8'h0A,
  localparam int         IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [IDW-1:0]       grant_id_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOCKED
`ifdef UART_ARB_TAG_EN
    , TAG0,
    TAG1
`endif
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [15:0]    byte_cnt;
  logic [15:0]    idle_cnt;
`ifdef UART_ARB_TAG_EN
  logic           have_prev;
`endif

  logic           any_req;
  logic [IDW-1:0] next_id;
  logic [IDW-1:0] cand;
  logic           sel_valid;
  logic [7:0]     sel_data;
  logic           hs;
  logic [15:0]    byte_cnt_inc;
  logic           release_grant;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Round-robin search starting just after the last released grantee
  always_comb begin
    any_req = 1'b0;
    next_id = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDW'((int'(ptr) + i) % NUM_REQ);
      if (!any_req && req_valid_i[cand]) begin
        any_req = 1'b1;
        next_id = cand;
      end
    end
  end

  assign sel_valid = req_valid_i[grant_id_o];
  assign sel_data  = req_data_i[{grant_id_o, 3'b000} +: 8];

  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    req_ready_o = '0;
    case (state)
      LOCKED: begin
        tx_valid_o              = sel_valid;
        tx_data_o               = sel_data;
        req_ready_o[grant_id_o] = tx_ready_i;
      end
`ifdef UART_ARB_TAG_EN
      TAG0: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h30 + 8'(grant_id_o);
      end
      TAG1: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h3A;
      end
`endif
      default: ;
    endcase
  end

  assign hs           = (state == LOCKED) && sel_valid && tx_ready_i;
  assign byte_cnt_inc = sat_inc(byte_cnt);
  assign release_grant = (state == LOCKED) &&
                         ((hs && (sel_data == EOM_CHAR)) ||
                          (hs && (byte_cnt_inc == 16'(MAX_HOLD))) ||
                          (!sel_valid && (sat_inc(idle_cnt) == 16'(IDLE_TIMEOUT))));

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant_o    <= '0;
      grant_id_o <= '0;
      ptr        <= IDW'(NUM_REQ - 1);
      byte_cnt   <= '0;
      idle_cnt   <= '0;
`ifdef UART_ARB_TAG_EN
      have_prev  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_o    <= NUM_REQ'(1) << next_id;
            grant_id_o <= next_id;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
`ifdef UART_ARB_TAG_EN
            have_prev  <= 1'b1;
            state      <= (!have_prev || (next_id != grant_id_o)) ? TAG0 : LOCKED;
`else
            state      <= LOCKED;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG0: if (tx_ready_i) state <= TAG1;
        TAG1: if (tx_ready_i) state <= LOCKED;
`endif
        LOCKED: begin
          if (release_grant) begin
            state    <= IDLE;
            grant_o  <= '0;
            ptr      <= grant_id_o;
            byte_cnt <= '0;
            idle_cnt <= '0;
          end else begin
            if (hs) byte_cnt <= byte_cnt_inc;
            idle_cnt <= sel_valid ? 16'd0 : sat_inc(idle_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes queued as requesters drive them.
module tb_uart_tx_arbiter;
  localparam int N = 4;
`ifdef UART_ARB_TAG_EN
  localparam int TAGC = 2;
`else
  localparam int TAGC = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic [1:0]     grant_id;
  logic           busy;

  logic       v[N];
  logic [7:0] d[N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = v[i];
      req_data[8*i +: 8]  = d[i];
    end
  end

  uart_tx_arbiter #(
    .NUM_REQ(N), .MAX_HOLD(4), .IDLE_TIMEOUT(8), .EOM_CHAR(8'h0A)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .grant_o(grant), .grant_id_o(grant_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] sb[$];
  bit mdl_first = 1'b1;
  int mdl_last  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_msg(input int id, input string s);
`ifdef UART_ARB_TAG_EN
    if (mdl_first || id != mdl_last) begin
      sb.push_back({4'(id), 8'h30 + 8'(id)});
      sb.push_back({4'(id), 8'h3A});
    end
`endif
    mdl_first = 1'b0;
    mdl_last  = id;
    for (int i = 0; i < s.len(); i++) sb.push_back({4'(id), s[i]});
  endtask

  // Output side of the scoreboard: every accepted byte must match the queue head
  always @(negedge clk) begin
    logic [11:0] exp;
    if (!rst && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra_byte", {20'h0, 4'(grant_id), tx_data}, 32'h0000_1000);
      end else begin
        exp = sb.pop_front();
        check("sb_byte", {20'h0, 4'(grant_id), tx_data}, {20'h0, exp});
        check("sb_grant", 32'(grant), 32'(1) << exp[11:8]);
      end
    end
  end

  task automatic send_byte(input int k, input logic [7:0] b);
    int n;
    n = 0;
    v[k] = 1'b1;
    d[k] = b;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[k] && n < 300);
    if (n >= 300) check("hs_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic send(input int k, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(k, s[i]);
    v[k] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mdl_first = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    rst = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      d[i] = 8'h00;
    end
    #3;
    check("rst_grant", grant, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_data", tx_data, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // "hi\n" from req0 with serializer always ready
    c0 = cyc;
    push_msg(0, "hi\n");
    send(0, "hi\n");
    check("t1_cycles", cyc - c0, 4 + TAGC);
    check("t1_busy_after_eom", busy, 0);
    check("t1_grant_after_eom", grant, 0);
    check("t1_grant_id_last", grant_id, 0);

    // req0 and req2 valid together straight from reset
    do_reset();
    c0 = cyc;
    push_msg(0, "A\n");
    push_msg(2, "B\n");
    fork
      send(0, "A\n");
      send(2, "B\n");
    join
    check("t2_cycles", cyc - c0, 6 + 2 * TAGC);
    check("t2_grant_id_last", grant_id, 2);

    // MAX_HOLD forced release lets req3 in between req1 chunks
    push_msg(1, "abcd");
    push_msg(3, "Z\n");
    push_msg(1, "efgh");
    push_msg(1, "ij");
    fork
      send(1, "abcdefghij");
      begin
        repeat (2) @(posedge clk);
        #1;
        send(3, "Z\n");
      end
    join
    wait_idle("t3_release");

    // Idle timeout: release 8 cycles after valid drops
    push_msg(0, "x");
    send(0, "x");
    check("t4_grant_held", grant, 4'b0001);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (grant != 0 && n < 40);
    check("t4_timeout_cycles", n, 8);
    check("t4_busy", busy, 0);

    // Serializer stall mid-message
    push_msg(2, "pq\n");
    fork
      send(2, "pq\n");
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(tx_valid && tx_data == 8'h70 && grant_id == 2) && n < 100);
        check("t5_saw_p", n < 100, 1);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("t5_hold_data", tx_data, 8'h71);
          check("t5_ready_low", req_ready, 0);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
      end
    join
    wait_idle("t5_release");

    // Reset mid-message, then req0 must win against req3
    push_msg(3, "ab");
    send_byte(3, 8'h61);
    send_byte(3, 8'h62);
    d[3] = 8'h63;
    #2 rst = 1'b1;
    #1;
    check("t6_tx_valid", tx_valid, 0);
    check("t6_tx_data", tx_data, 0);
    check("t6_grant", grant, 0);
    check("t6_grant_id", grant_id, 0);
    check("t6_busy", busy, 0);
    check("t6_req_ready", req_ready, 0);
    v[3] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    mdl_first = 1'b1;
    push_msg(0, "ok\n");
    push_msg(3, "r\n");
    fork
      send(0, "ok\n");
      send(3, "r\n");
    join
    wait_idle("t6_release");

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
